// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
//
// Serial pattern transmitter that generates stimulus for the 11011 sequence
// detector. A start request in IDLE captures a PAT_W-bit pattern (either the
// pattern input or PAT_DEFAULT), a frame repeat count and an inter-frame gap.
// The pattern is then shifted out MSB-first, one bit per clock, repeat_n times,
// with gap_len zero bits between consecutive frames.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        transmit request, honoured only in IDLE
//   use_default  1: send PAT_DEFAULT, 0: send pattern
//   pattern      user pattern, bit PAT_W-1 goes out first
//   repeat_n     number of frames to send (0 = empty request)
//   gap_len      idle bits inserted between frames
//   x_out        serial data bit (0 whenever valid is low)
//   valid        x_out carries a pattern bit this cycle
//   busy         transmission in progress (SEND or GAP)
//   frame_end    high together with bit 0 of every frame
//   done         one-cycle pulse after the last frame or an empty request
//
// Every output comes straight from a flop. The output flops are loaded from
// the *next* state, so in any cycle the outputs describe the state the FSM
// occupies in that same cycle, and no input reaches an output without a flop.
// -----------------------------------------------------------------------------
module seq_pattern_tx #(
    parameter int              PAT_W       = 5,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = 5'b11011,
    parameter int              CNT_W       = 4,
    parameter int              GAP_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap_len,
    output logic             x_out,
    output logic             valid,
    output logic             busy,
    output logic             frame_end,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] bit_idx_q,   bit_idx_d;
    logic [CNT_W-1:0] frames_q,    frames_d;
    logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
    logic [GAP_W-1:0] gap_len_q,   gap_len_d;
    logic [PAT_W-1:0] pat_q,       pat_d;

    logic             x_out_q,     x_out_d;
    logic             valid_q,     valid_d;
    logic             busy_q,      busy_d;
    logic             frame_end_q, frame_end_d;
    logic             done_q,      done_d;

    logic [CNT_W-1:0] frames_left;

    // Frames still owed once the current frame's bit 0 has gone out.
    assign frames_left = frames_q - CNT_W'(1);

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        frames_d  = frames_q;
        gap_cnt_d = gap_cnt_q;
        gap_len_d = gap_len_q;
        pat_d     = pat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d     = use_default ? PAT_DEFAULT : pattern;
                    frames_d  = repeat_n;
                    gap_len_d = gap_len;
                    bit_idx_d = IDX_MSB;
                    state_d   = (repeat_n == '0) ? ST_DONE : ST_SEND;
                end
            end

            ST_SEND: begin
                if (bit_idx_q == '0) begin
                    frames_d = frames_left;
                    if (frames_left == '0) begin
                        state_d = ST_DONE;
                    end else if (gap_len_q != '0) begin
                        // gap_cnt holds the number of gap cycles still to
                        // spend, counting the one being entered.
                        gap_cnt_d = gap_len_q;
                        state_d   = ST_GAP;
                    end else begin
                        // Back-to-back: next MSB follows bit 0 with no bubble.
                        bit_idx_d = IDX_MSB;
                    end
                end else begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    bit_idx_d = IDX_MSB;
                    state_d   = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            ST_DONE: begin
                // One-cycle completion state; a request here is not honoured.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs line up
    // with the state being occupied in the following cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        x_out_d     = 1'b0;
        valid_d     = 1'b0;
        busy_d      = 1'b0;
        frame_end_d = 1'b0;
        done_d      = 1'b0;

        unique case (state_d)
            ST_SEND: begin
                x_out_d     = pat_d[bit_idx_d];
                valid_d     = 1'b1;
                busy_d      = 1'b1;
                frame_end_d = (bit_idx_d == '0);
            end
            ST_GAP: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                x_out_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, latches and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            frames_q    <= '0;
            gap_cnt_q   <= '0;
            gap_len_q   <= '0;
            pat_q       <= '0;
            x_out_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_end_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            frames_q    <= frames_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_len_q   <= gap_len_d;
            pat_q       <= pat_d;
            x_out_q     <= x_out_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            frame_end_q <= frame_end_d;
            done_q      <= done_d;
        end
    end

    assign x_out     = x_out_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_end = frame_end_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_tx
//
// Directed bench for seq_pattern_tx. Each scenario lists the expected value of
// every output for each cycle after the start edge as a bit string, first
// cycle in the leftmost position.
// -----------------------------------------------------------------------------
module tb_seq_pattern_tx;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       use_default;
    logic [4:0] pattern;
    logic [3:0] repeat_n;
    logic [3:0] gap_len;
    logic       x_out;
    logic       valid;
    logic       busy;
    logic       frame_end;
    logic       done;

    int n_checks;
    int n_errors;

    seq_pattern_tx #(
        .PAT_W       (5),
        .PAT_DEFAULT (5'b11011),
        .CNT_W       (4),
        .GAP_W       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .use_default (use_default),
        .pattern     (pattern),
        .repeat_n    (repeat_n),
        .gap_len     (gap_len),
        .x_out       (x_out),
        .valid       (valid),
        .busy        (busy),
        .frame_end   (frame_end),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] obs;
    assign obs = {x_out, valid, busy, frame_end, done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue a request (start high before edge 0), then check cycles 1..n.
    // start drops after cycle start_off is sampled; a disturbing request with
    // scrambled inputs is raised during cycle pulse_at (0 = none).
    task automatic run_case(input string tag, input logic dflt, input logic [4:0] pat,
                            input logic [3:0] rep, input logic [3:0] gap, input int n,
                            input logic [31:0] xs, input logic [31:0] vs,
                            input logic [31:0] bs, input logic [31:0] fs,
                            input logic [31:0] ds, input int start_off, input int pulse_at);
        logic [4:0] exp;
        use_default = dflt;
        pattern     = pat;
        repeat_n    = rep;
        gap_len     = gap;
        start       = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            exp = {xs[n-c], vs[n-c], bs[n-c], fs[n-c], ds[n-c]};
            check($sformatf("%s_c%0d", tag, c), 32'(obs), 32'(exp));
            if (c == start_off) start = 1'b0;
            if (pulse_at != 0 && c == pulse_at) begin
                start       = 1'b1;
                use_default = ~dflt;
                pattern     = ~pat;
                repeat_n    = 4'd7;
                gap_len     = 4'd2;
            end
            if (pulse_at != 0 && c == pulse_at + 1) start = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        use_default = 1'b1;
        pattern     = 5'b00000;
        repeat_n    = 4'd0;
        gap_len     = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(obs), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 32'(obs), 32'd0);

        // Default single frame, then one idle cycle.
        run_case("dflt1", 1'b1, 5'b00000, 4'd1, 4'd0, 7,
                 32'b1101100, 32'b1111100, 32'b1111100, 32'b0000100, 32'b0000010, 1, 0);

        // Two frames separated by three gap bits.
        run_case("gap3", 1'b0, 5'b11011, 4'd2, 4'd3, 15,
                 32'b110110001101100, 32'b111110001111100, 32'b111111111111100,
                 32'b000010000000100, 32'b000000000000010, 1, 0);

        // Three frames back-to-back.
        run_case("b2b", 1'b1, 5'b00000, 4'd3, 4'd0, 17,
                 32'b11011110111101100, 32'b11111111111111100, 32'b11111111111111100,
                 32'b00001000010000100, 32'b00000000000000010, 1, 0);

        // Empty request.
        run_case("empty", 1'b1, 5'b00000, 4'd0, 4'd3, 3,
                 32'b000, 32'b000, 32'b000, 32'b000, 32'b100, 1, 0);

        // Custom pattern with a new request and input changes during cycle 3.
        run_case("ignore", 1'b0, 5'b10010, 4'd1, 4'd0, 7,
                 32'b1001000, 32'b1111100, 32'b1111100, 32'b0000100, 32'b0000010, 1, 3);

        // start held high across two runs.
        run_case("hold", 1'b0, 5'b10010, 4'd1, 4'd0, 14,
                 32'b10010001001000, 32'b11111001111100, 32'b11111001111100,
                 32'b00001000000100, 32'b00000100000010, 13, 0);

        // Asynchronous reset in the middle of a frame.
        use_default = 1'b1;
        repeat_n    = 4'd1;
        gap_len     = 4'd0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_pre_c3", 32'(obs), 32'(5'b01100));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        check("rst_held", 32'(obs), 32'd0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_idle_%0d", i), 32'(obs), 32'd0);
        end
        run_case("rst_frame", 1'b1, 5'b00000, 4'd1, 4'd0, 7,
                 32'b1101100, 32'b1111100, 32'b1111100, 32'b0000100, 32'b0000010, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
